// File: rtl/pf_lanectrl_pause_pkg.sv
// Shared definitions for the lane-controller clock-pause protocol.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
//
// Used by both the initiator-side sequencer and the downstream pause
// synchroniser so that both ends agree on the synchroniser latency.
package pf_lanectrl_pause_pkg;

  // Largest legal value for any of the cycle-count parameters.
  localparam int unsigned MAX_CYCLES = 255;

  // Shared down-counter width: must hold MAX_CYCLES + max sync latency (2).
  localparam int unsigned CNT_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_UPDATE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } pause_state_e;

  // Pause synchroniser latency for a given ENABLE_PAUSE_EXTENSION mode.
  // Mode 3'b000 is a straight pass-through; 3'b001..3'b100 add two flops.
  function automatic int unsigned sync_lat(input logic [2:0] mode);
    return (mode == 3'b000) ? 0 : 2;
  endfunction

endpackage

// File: rtl/pf_lanectrl_pause_seq.sv
// Initiator-side clock-pause sequencer: pause, delay-code update, release, ack.
// Latency: PAUSE/BUSY one cycle after REQ accept; ACK at
//   1+SETUP+SYNC_LAT+1+HOLD+RELEASE+SYNC_LAT cycles after accept.
// Backpressure: none; REQ and CODE_IN are ignored while BUSY.
//
// Ports:
//   CLK, RESET       fabric clock, async active-high reset
//   REQ              level request, sampled only in IDLE
//   CODE_IN          delay code, captured on the accept edge
//   HS_IO_CLK_PAUSE  pause request to the downstream synchroniser
//   DELAY_UPDATE     one-cycle update strobe to the lane controller
//   CODE_OUT         captured code, held until the next accept
//   BUSY             high while a sequence is in progress
//   ACK              one-cycle completion pulse
module pf_lanectrl_pause_seq
  import pf_lanectrl_pause_pkg::*;
#(
  parameter logic [2:0]  ENABLE_PAUSE_EXTENSION = 3'b000,
  parameter int unsigned SETUP_CYCLES           = 4,
  parameter int unsigned HOLD_CYCLES            = 2,
  parameter int unsigned RELEASE_CYCLES         = 4,
  parameter int unsigned CODE_W                 = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  input  logic [CODE_W-1:0] CODE_IN,
  output logic              HS_IO_CLK_PAUSE,
  output logic              DELAY_UPDATE,
  output logic [CODE_W-1:0] CODE_OUT,
  output logic              BUSY,
  output logic              ACK
);

  localparam int unsigned SYNC_LAT = sync_lat(ENABLE_PAUSE_EXTENSION);

  // Counter load values; each phase runs until the counter reads zero, so
  // a load of N-1 gives N cycles in that phase.
  localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYCLES + SYNC_LAT - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD    = (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_CYCLES + SYNC_LAT - 1);

  // Reject illegal configurations at elaboration.
  if (SETUP_CYCLES == 0 || SETUP_CYCLES > MAX_CYCLES) begin : g_bad_setup
    $error("pf_lanectrl_pause_seq: SETUP_CYCLES=%0d out of range 1..%0d", SETUP_CYCLES, MAX_CYCLES);
  end
  if (HOLD_CYCLES > MAX_CYCLES) begin : g_bad_hold
    $error("pf_lanectrl_pause_seq: HOLD_CYCLES=%0d out of range 0..%0d", HOLD_CYCLES, MAX_CYCLES);
  end
  if (RELEASE_CYCLES == 0 || RELEASE_CYCLES > MAX_CYCLES) begin : g_bad_release
    $error("pf_lanectrl_pause_seq: RELEASE_CYCLES=%0d out of range 1..%0d", RELEASE_CYCLES, MAX_CYCLES);
  end
  if (ENABLE_PAUSE_EXTENSION > 3'b100) begin : g_bad_mode
    $error("pf_lanectrl_pause_seq: ENABLE_PAUSE_EXTENSION=%0d is not a defined mode", ENABLE_PAUSE_EXTENSION);
  end
  if (CODE_W == 0) begin : g_bad_code_w
    $error("pf_lanectrl_pause_seq: CODE_W must be at least 1");
  end

  pause_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;

  logic              pause_q, upd_q, busy_q, ack_q;
  logic [CODE_W-1:0] code_q;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LOAD;
          accept  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_UPDATE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_UPDATE: begin
        // With no hold time the pause is released straight after the strobe.
        if (HOLD_CYCLES == 0) begin
          state_d = ST_RELEASE;
          cnt_d   = RELEASE_LOAD;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_RELEASE;
          cnt_d   = RELEASE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and output registers. Outputs are decoded from the next
  // state so they are flop outputs aligned with the state they describe.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pause_q <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pause_q <= (state_d == ST_SETUP) || (state_d == ST_UPDATE) || (state_d == ST_HOLD);
      upd_q   <= (state_d == ST_UPDATE);
      busy_q  <= (state_d != ST_IDLE);
      ack_q   <= (state_d == ST_DONE);
      if (accept) begin
        code_q <= CODE_IN;
      end
    end
  end

  assign HS_IO_CLK_PAUSE = pause_q;
  assign DELAY_UPDATE    = upd_q;
  assign BUSY            = busy_q;
  assign ACK             = ack_q;
  assign CODE_OUT        = code_q;

endmodule
